seg_message_scanner: RTL and testbench

Parametrised, multiplexed seven-segment display engine for the stopwatch front panel. It generalises the single-digit error/saver glyph decoder into a sequential block that does four things: scans NUM_DIGITS common-anode digits, shows BCD time digits, shows a blinking error message with a hex code, and runs a screen-saver chase around the whole display perimeter. It sits between the stopwatch control FSM and the board's segment/anode pins.

---
 rtl/seg_message_scanner.sv | 172 +++++++++++++++++
 tb/tb_seg_message_scanner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_message_scanner.sv
// seg_message_scanner: multiplexed seven-segment engine for the stopwatch panel.
// Normal BCD, blinking error text, perimeter chase saver and blank modes.
module seg_message_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int STEP_DIV   = 5000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [3:0]              err_code,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int PN = 2 * NUM_DIGITS + 4;
  localparam int PW = $clog2(PN);
  localparam int N  = NUM_DIGITS;

  localparam logic [DW-1:0] DIV_TC  = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_TC  = IW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] STEP_TC = SW'(STEP_DIV - 1);
  localparam logic [PW-1:0] POS_TC  = PW'(PN - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  typedef enum logic [1:0] {
    M_NORM  = 2'b00,
    M_ERR   = 2'b01,
    M_SAV   = 2'b10,
    M_BLANK = 2'b11
  } mode_t;

  logic [DW-1:0] div_cnt;
  logic [IW-1:0] dig_idx;
  logic [SW-1:0] step_cnt;
  logic [PW-1:0] pos;
  logic          visible;
  mode_t         mode_q;

  logic          step_tick;
  logic          enter;
  logic          enter_sav;
  logic          enter_err;
  logic [PW-1:0] pos_eff;
  logic          vis_eff;
  logic [3:0]    nib;
  logic [7:0]    norm_glyph;
  logic [7:0]    err_glyph;
  logic [7:0]    sav_glyph;
  logic [7:0]    seg_nxt;
  int            p;
  int            d;

  function automatic logic [7:0] hex_glyph(input logic [3:0] v);
    logic [7:0] g;
    case (v)
      4'h0:    g = 8'hFC;
      4'h1:    g = 8'h60;
      4'h2:    g = 8'hDA;
      4'h3:    g = 8'hF2;
      4'h4:    g = 8'h66;
      4'h5:    g = 8'hB6;
      4'h6:    g = 8'hBE;
      4'h7:    g = 8'hE0;
      4'h8:    g = 8'hFE;
      4'h9:    g = 8'hF6;
      4'hA:    g = 8'hEE;
      4'hB:    g = 8'h3E;
      4'hC:    g = 8'h9C;
      4'hD:    g = 8'h7A;
      4'hE:    g = 8'h9E;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

  assign step_tick = (step_cnt == STEP_TC);
  assign enter     = (mode != mode_q);
  assign enter_sav = enter && (mode == M_SAV);
  assign enter_err = enter && (mode == M_ERR);

  // Entry state is shown on the entry edge itself.
  assign pos_eff = enter_sav ? '0 : pos;
  assign vis_eff = enter_err ? 1'b1 : visible;

  always_comb begin
    nib        = digits_in[4*int'(dig_idx) +: 4];
    norm_glyph = (nib <= 4'd9) ? hex_glyph(nib) : 8'h02;
    norm_glyph = norm_glyph | {7'd0, dp_in[dig_idx]};
  end

  always_comb begin
    err_glyph = 8'h02;
    if (dig_idx == '0)
      err_glyph = hex_glyph(err_code);
    else if (dig_idx == IDX_TC)
      err_glyph = 8'h9E;
    if (!vis_eff)
      err_glyph = 8'h00;
  end

  always_comb begin
    sav_glyph = 8'h00;
    p = int'(pos_eff);
    d = int'(dig_idx);
    unique case (1'b1)
      (p < N):
        if (d == N - 1 - p) sav_glyph = 8'h80;
      (p == N):
        if (d == 0) sav_glyph = 8'h40;
      (p == N + 1):
        if (d == 0) sav_glyph = 8'h20;
      (p >= N + 2 && p <= 2 * N + 1):
        if (d == p - N - 2) sav_glyph = 8'h10;
      (p == 2 * N + 2):
        if (d == N - 1) sav_glyph = 8'h08;
      default:
        if (d == N - 1) sav_glyph = 8'h04;
    endcase
  end

  always_comb begin
    seg_nxt = 8'h00;
    unique case (mode)
      M_NORM:  seg_nxt = norm_glyph;
      M_ERR:   seg_nxt = err_glyph;
      M_SAV:   seg_nxt = sav_glyph;
      default: seg_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      dig_idx  <= '0;
      step_cnt <= '0;
      pos      <= '0;
      visible  <= 1'b1;
      mode_q   <= M_NORM;
      seg_n    <= 8'hFF;
      an_n     <= '1;
    end else begin
      mode_q <= mode_t'(mode);
      if (div_cnt == DIV_TC) begin
        div_cnt <= '0;
        dig_idx <= (dig_idx == IDX_TC) ? '0 : dig_idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (enter_sav || enter_err || step_tick)
        step_cnt <= '0;
      else
        step_cnt <= step_cnt + 1'b1;
      if (enter_sav)
        pos <= '0;
      else if (step_tick && mode == M_SAV)
        pos <= (pos == POS_TC) ? '0 : pos + 1'b1;
      if (enter_err)
        visible <= 1'b1;
      else if (step_tick && mode == M_ERR)
        visible <= ~visible;
      seg_n <= ~seg_nxt;
      an_n  <= ~(AN_ONE << dig_idx);
    end
  end

endmodule

// File: tb/tb_seg_message_scanner.sv
// Scoreboard bench for seg_message_scanner: a reference model predicts
// each registered pin update; a monitor pops and compares after each edge.
module tb_seg_message_scanner;

  localparam int N    = 4;
  localparam int SCAN = 4;
  localparam int STEP = 8;
  localparam int PN   = 2 * N + 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [1:0]     mode = 2'b00;
  logic [4*N-1:0] digits_in = '0;
  logic [N-1:0]   dp_in = '0;
  logic [3:0]     err_code = '0;
  logic [7:0]     seg_n;
  logic [N-1:0]   an_n;

  seg_message_scanner #(
    .NUM_DIGITS(N),
    .SCAN_DIV(SCAN),
    .STEP_DIV(STEP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode(mode),
    .digits_in(digits_in),
    .dp_in(dp_in),
    .err_code(err_code),
    .seg_n(seg_n),
    .an_n(an_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [7:0] seg;
    logic [3:0] an;
  } exp_t;

  exp_t       q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         k = 0;
  int         e = 0;
  logic [1:0] prev_mode = 2'b00;

  logic [7:0] hex_tab [16];
  int         per_dig [PN];
  logic [7:0] per_seg [PN];

  // Perimeter walk: top row left to right, right edge, bottom row
  // right to left, left edge.
  initial begin
    hex_tab = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
    for (int i = 0; i < N; i++) begin
      per_dig[i] = N - 1 - i;
      per_seg[i] = 8'h80;
      per_dig[N + 2 + i] = i;
      per_seg[N + 2 + i] = 8'h10;
    end
    per_dig[N] = 0;         per_seg[N] = 8'h40;
    per_dig[N + 1] = 0;     per_seg[N + 1] = 8'h20;
    per_dig[2 * N + 2] = N - 1; per_seg[2 * N + 2] = 8'h08;
    per_dig[2 * N + 3] = N - 1; per_seg[2 * N + 3] = 8'h04;
  end

  // kk: edges since reset release; ee: edge of the last error/saver entry.
  function automatic exp_t model(input int kk, input int ee,
                                 input logic [1:0] m);
    exp_t       r;
    int         d;
    int         steps;
    logic [7:0] g;
    logic [3:0] nib;
    d = (kk / SCAN) % N;
    steps = (kk == ee) ? 0 : (kk - 1 - ee) / STEP;
    g = 8'h00;
    case (m)
      2'b00: begin
        nib = digits_in[4*d +: 4];
        g = (nib < 4'd10) ? hex_tab[nib] : 8'h02;
        if (dp_in[d]) g = g | 8'h01;
      end
      2'b01: begin
        if (steps % 2 == 0) begin
          if (d == 0) g = hex_tab[err_code];
          else if (d == N - 1) g = 8'h9E;
          else g = 8'h02;
        end
      end
      2'b10: begin
        if (per_dig[steps % PN] == d) g = per_seg[steps % PN];
      end
      default: g = 8'h00;
    endcase
    r.k = kk;
    r.seg = ~g;
    r.an = ~(4'b0001 << d);
    return r;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [7:0] aseg, input logic [3:0] aan,
                     input logic [7:0] eseg, input logic [3:0] ean);
    vectors++;
    if (aseg !== eseg || aan !== ean) begin
      miscompares++;
      $display("FAIL %s edge %0d: got seg_n=%h an_n=%h, expected seg_n=%h an_n=%h",
               name, idx, aseg, aan, eseg, ean);
    end
  endtask

  task automatic drive_push(input logic [1:0] m, input logic [15:0] dg,
                            input logic [3:0] dp, input logic [3:0] er);
    mode = m;
    digits_in = dg;
    dp_in = dp;
    err_code = er;
    if (m != prev_mode && (m == 2'b01 || m == 2'b10)) e = k;
    prev_mode = m;
    q.push_back(model(k, e, m));
    k++;
  endtask

  task automatic cyc(input logic [1:0] m, input logic [15:0] dg,
                     input logic [3:0] dp, input logic [3:0] er);
    @(negedge clk);
    drive_push(m, dg, dp, er);
  endtask

  task automatic hold_reset();
    chk("reset_async", -1, seg_n, an_n, 8'hFF, 4'hF);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset_hold", -1, seg_n, an_n, 8'hFF, 4'hF);
    end
  endtask

  task automatic release_reset(input logic [1:0] m);
    @(negedge clk);
    q.delete();
    k = 0;
    e = 0;
    prev_mode = 2'b00;
    rst_n = 1'b1;
    drive_push(m, digits_in, dp_in, err_code);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("pins", x.k, seg_n, an_n, x.seg, x.an);
      end
    end
  end

  initial begin : stim
    logic [1:0] m;
    int         hold;
    #1;
    rst_n = 1'b0;
    #1;
    hold_reset();
    digits_in = 16'h12B4;
    dp_in = 4'b0100;
    err_code = 4'hC;
    release_reset(2'b00);
    repeat (40) cyc(2'b00, 16'h12B4, 4'b0100, 4'hC);
    repeat (40) cyc(2'b01, 16'h12B4, 4'b0100, 4'hC);
    repeat (100) cyc(2'b10, 16'h12B4, 4'b0100, 4'hC);
    // Enter error, then saver, exactly on a step tick edge.
    while ((k - e) % STEP != 0) cyc(2'b10, 16'h12B4, 4'b0100, 4'hC);
    cyc(2'b01, 16'h12B4, 4'b0100, 4'h5);
    repeat (20) cyc(2'b01, 16'h12B4, 4'b0100, 4'h5);
    while ((k - e) % STEP != 0) cyc(2'b01, 16'h12B4, 4'b0100, 4'h5);
    cyc(2'b10, 16'h12B4, 4'b0100, 4'h5);
    repeat (30) cyc(2'b10, 16'h12B4, 4'b0100, 4'h5);
    // Reset in the middle of the chase at pos 7.
    while (((k - 1 - e) / STEP) % PN != 7) cyc(2'b10, 16'h12B4, 4'b0100, 4'h5);
    repeat (3) cyc(2'b10, 16'h12B4, 4'b0100, 4'h5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    hold_reset();
    release_reset(2'b10);
    repeat (40) cyc(2'b10, 16'h12B4, 4'b0100, 4'h5);
    repeat (20) cyc(2'b11, 16'h12B4, 4'b0100, 4'h5);
    hold = 0;
    m = 2'b00;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        m = 2'($urandom_range(0, 3));
        hold = $urandom_range(1, 30);
      end
      hold--;
      cyc(m, 16'($urandom), 4'($urandom), 4'($urandom));
    end
    @(negedge clk);
    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected updates never compared, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
